// File: rtl/display_scan.sv
// Time-multiplexed scanner for a 4-digit 7-segment stopwatch display.
// Rotates secm -> secd -> sec -> dsec, holding each digit SCAN_DIV clocks, with registered outputs.
module display_scan #(
  parameter int SCAN_DIV      = 1,
  parameter bit EN_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] dsec,
  input  logic [3:0] sec,
  input  logic [3:0] secd,
  input  logic [3:0] secm,
  output logic [3:0] scan_data,
  output logic [3:0] scan_en
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  // XOR mask: all-inactive enable pattern, also used to flip polarity of the one-hot
  localparam logic [3:0] EN_OFF = EN_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [3:0]       digit_sel;
  logic [3:0]       en_sel;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    onehot = 4'b0001 << sel;
  endfunction

  always_comb begin
    digit_sel = secm;
    case (idx)
      2'd0: digit_sel = secm;
      2'd1: digit_sel = secd;
      2'd2: digit_sel = sec;
      2'd3: digit_sel = dsec;
      default: digit_sel = secm;
    endcase
    en_sel = onehot(idx) ^ EN_OFF;
  end

  // Output register stage: outputs reflect the digit idx selected before this edge
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      div_cnt   <= '0;
      idx       <= 2'd0;
      scan_data <= 4'h0;
      scan_en   <= EN_OFF;
    end else begin
      scan_data <= digit_sel;
      scan_en   <= en_sel;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: three instances cover SCAN_DIV=1, SCAN_DIV=4 and active-low enables.
module tb_display_scan;

  logic       clk;
  logic       clrn;
  logic [3:0] dsec, sec, secd, secm;
  logic [3:0] a_data, a_en;
  logic [3:0] b_data, b_en;
  logic [3:0] c_data, c_en;

  int vectors;
  int miscompares;

  display_scan #(.SCAN_DIV(1), .EN_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .clrn(clrn), .dsec(dsec), .sec(sec), .secd(secd), .secm(secm),
    .scan_data(a_data), .scan_en(a_en));

  display_scan #(.SCAN_DIV(4), .EN_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .clrn(clrn), .dsec(dsec), .sec(sec), .secd(secd), .secm(secm),
    .scan_data(b_data), .scan_en(b_en));

  display_scan #(.SCAN_DIV(1), .EN_ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .clrn(clrn), .dsec(dsec), .sec(sec), .secd(secd), .secm(secm),
    .scan_data(c_data), .scan_en(c_en));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two clocks with the given digits, releases it on a falling edge.
  task automatic start_scan(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    @(negedge clk);
    clrn = 1'b1;
    dsec = d3; sec = d2; secd = d1; secm = d0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    dsec = 4'd1; sec = 4'd4; secd = 4'd6; secm = 4'd8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (a_data !== 4'h0 || a_en !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_a cycle %0d: got (%h,%b) want (0,0000)", i, a_data, a_en);
      end
      vectors++;
      if (b_data !== 4'h0 || b_en !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_b cycle %0d: got (%h,%b) want (0,0000)", i, b_data, b_en);
      end
      vectors++;
      if (c_data !== 4'h0 || c_en !== 4'b1111) begin
        miscompares++;
        $display("FAIL reset_c cycle %0d: got (%h,%b) want (0,1111)", i, c_data, c_en);
      end
    end
  endtask

  task automatic test_scan_div1();
    logic [3:0] exp_d [5] = '{4'd8, 4'd6, 4'd4, 4'd1, 4'd8};
    logic [3:0] exp_e [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    start_scan(4'd1, 4'd4, 4'd6, 4'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (a_data !== exp_d[i] || a_en !== exp_e[i]) begin
        miscompares++;
        $display("FAIL scan_div1 edge %0d: got (%h,%b) want (%h,%b)",
                 i + 1, a_data, a_en, exp_d[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_input_change();
    // after edge 2 the next slot is sec, so new values appear as sec, dsec, secm, secd
    logic [3:0] exp_d [4] = '{4'd5, 4'd2, 4'd9, 4'd7};
    logic [3:0] exp_e [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    start_scan(4'd1, 4'd4, 4'd6, 4'd8);
    @(negedge clk);
    @(negedge clk);
    dsec = 4'd2; sec = 4'd5; secd = 4'd7; secm = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (a_data !== exp_d[i] || a_en !== exp_e[i]) begin
        miscompares++;
        $display("FAIL input_change slot %0d: got (%h,%b) want (%h,%b)",
                 i, a_data, a_en, exp_d[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    start_scan(4'd1, 4'd4, 4'd6, 4'd8);
    repeat (3) @(negedge clk);
    vectors++;
    if (a_data !== 4'd4 || a_en !== 4'b0100) begin
      miscompares++;
      $display("FAIL async_pre: got (%h,%b) want (4,0100)", a_data, a_en);
    end
    #2 clrn = 1'b1;
    #1;
    vectors++;
    if (a_data !== 4'h0 || a_en !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_clear: got (%h,%b) want (0,0000)", a_data, a_en);
    end
    vectors++;
    if (c_en !== 4'b1111) begin
      miscompares++;
      $display("FAIL async_clear_low: got %b want 1111", c_en);
    end
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_data !== 4'd8 || a_en !== 4'b0001) begin
      miscompares++;
      $display("FAIL async_restart: got (%h,%b) want (8,0001)", a_data, a_en);
    end
  endtask

  task automatic test_div4();
    logic [3:0] slot_d [4] = '{4'd8, 4'd6, 4'd4, 4'd1};
    logic [3:0] slot_e [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int s;
    start_scan(4'd1, 4'd4, 4'd6, 4'd8);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      s = ((k - 1) / 4) % 4;
      vectors++;
      if (b_data !== slot_d[s] || b_en !== slot_e[s]) begin
        miscompares++;
        $display("FAIL div4 edge %0d: got (%h,%b) want (%h,%b)",
                 k, b_data, b_en, slot_d[s], slot_e[s]);
      end
    end
  endtask

  task automatic test_active_low();
    logic [3:0] exp_d [5] = '{4'd8, 4'd6, 4'd4, 4'd1, 4'd8};
    logic [3:0] exp_e [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    start_scan(4'd1, 4'd4, 4'd6, 4'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (c_data !== exp_d[i] || c_en !== exp_e[i]) begin
        miscompares++;
        $display("FAIL active_low edge %0d: got (%h,%b) want (%h,%b)",
                 i + 1, c_data, c_en, exp_d[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_pass_through();
    logic [3:0] exp_d [4] = '{4'd11, 4'd10, 4'd12, 4'd15};
    logic [3:0] exp_e [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    start_scan(4'd15, 4'd12, 4'd10, 4'd11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (a_data !== exp_d[i] || a_en !== exp_e[i]) begin
        miscompares++;
        $display("FAIL pass_through edge %0d: got (%h,%b) want (%h,%b)",
                 i + 1, a_data, a_en, exp_d[i], exp_e[i]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_scan_div1();
    test_input_change();
    test_async_reset();
    test_div4();
    test_active_low();
    test_pass_through();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
